// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants and state encodings
package mips_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP = 32'h0000_0000;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry ins/pc4 holding register for a stalled fetch
module fetch_buffer import mips_pkg::*; (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] ins_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] ins,
    output logic [31:0] pc4,
    output logic        valid
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ins   <= NOP;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            ins   <= ins_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetch-stage PC, IM req/ack sequencing, delay-slot redirects
module pc_fetch_sequencer import mips_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        change,
    input  logic [31:0] pc_new,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_F,
    output logic [31:0] pc4_F,
    output logic        valid_F,
    output logic        misalign
);
    fetch_state_t state;
    logic [31:0] pc, redir_pc, buf_ins, buf_pc4;
    logic        redir_pending, buf_valid;
    logic        fetch_ack, take, redirect, capture;
    logic [31:0] pc4, aligned, next_pc;

    assign pc4       = pc + 32'd4;
    assign aligned   = {pc_new[31:2], 2'b00};
    assign fetch_ack = (state == FETCH) && imem_ack;
    assign take      = !stall && (fetch_ack || state == HOLD);
    assign redirect  = change && !stall;
    // a redirect seen before its delay slot is delivered waits here; first target wins
    assign capture   = redirect && !redir_pending && !take;
    assign next_pc   = redir_pending ? redir_pc : redirect ? aligned : pc4;

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign valid_F   = fetch_ack || (state == HOLD && buf_valid);
    assign ins_F     = fetch_ack ? imem_rdata : (state == HOLD) ? buf_ins : NOP;
    assign pc4_F     = fetch_ack ? pc4 : (state == HOLD) ? buf_pc4 : '0;

    fetch_buffer u_buf (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (fetch_ack && stall),
        .clear  (state == HOLD && !stall),
        .ins_in (imem_rdata),
        .pc4_in (pc4),
        .ins    (buf_ins),
        .pc4    (buf_pc4),
        .valid  (buf_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            redir_pending <= 1'b0;
            redir_pc      <= '0;
            misalign      <= 1'b0;
        end else begin
            if (take) begin
                pc            <= next_pc;
                redir_pending <= 1'b0;
            end else if (capture) begin
                redir_pending <= 1'b1;
                redir_pc      <= aligned;
            end
            if (redirect && |pc_new[1:0])
                misalign <= 1'b1;
            state <= (state == IDLE) ? FETCH :
                     (fetch_ack && stall) ? HOLD :
                     (state == HOLD && !stall) ? FETCH : state;
        end
    end
endmodule
